video_pixel_sequencer: RTL and testbench



---
 rtl/video_pixel_sequencer_if.sv | 8 +
 rtl/video_pixel_sequencer.sv | 112 +++++++++++
 tb/tb_video_pixel_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/video_pixel_sequencer_if.sv
// video_pixel_sequencer_if: valid/ready word channel from the line FIFO to the pixel sequencer
interface video_pixel_sequencer_if;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready;
   modport master (output word_data, word_valid, input word_ready);
   modport slave (input word_data, word_valid, output word_ready);
endinterface

// File: rtl/video_pixel_sequencer.sv
// video_pixel_sequencer: steps pixel indices through prefetched FIFO words for the demux; optional VIDEO_PIXSEQ_DOUBLE_EN adds horizontal pixel doubling
module video_pixel_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  mode,
   input  logic        line_start,
   input  logic        pix_en,
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
   input  logic        hdouble,
`endif
   video_pixel_sequencer_if.slave bus,
   output logic [31:0] pixword,
   output logic [4:0]  x_index,
   output logic        pix_valid,
   output logic        underrun
);
   typedef enum logic [1:0] {IDLE, PRIME, RUN, UNDERRUN} state_t;
   state_t      state;
   logic [2:0]  mode_q;
   logic [31:0] pre_data;
   logic        pre_valid;
   logic        cur_valid;
   logic [5:0]  step;
   logic        act;
   logic        advance_word;
   logic        xfer;
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
   logic        hdouble_q;
   logic        phase;
   assign act = pix_en && state == RUN && (!hdouble_q || phase);
`else
   assign act = pix_en && state == RUN;
`endif
   // index stride per pixel for the latched depth; reserved modes fall back to 1bpp
   always_comb begin
      step = mode_q == 3'd1 ? 6'd2 :
             (mode_q == 3'd2 || mode_q == 3'd5) ? 6'd4 :
             mode_q == 3'd3 ? 6'd8 :
             mode_q == 3'd4 ? 6'd16 : 6'd1;
   end
   assign advance_word = act && ({1'b0, x_index} + step >= 6'd32);
   assign bus.word_ready = !reset && !line_start && (state == PRIME || state == RUN) && (!pre_valid || advance_word);
   assign xfer = bus.word_valid && bus.word_ready;
   // line FSM: prime current+prefetch words, then step through them until the line ends or the FIFO starves
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         mode_q    <= 3'd0;
         pixword   <= 32'd0;
         pre_data  <= 32'd0;
         pre_valid <= 1'b0;
         cur_valid <= 1'b0;
         x_index   <= 5'd0;
         pix_valid <= 1'b0;
         underrun  <= 1'b0;
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
         hdouble_q <= 1'b0;
         phase     <= 1'b0;
`endif
      end else if (line_start) begin
         state     <= PRIME;
         mode_q    <= mode;
         pre_valid <= 1'b0;
         cur_valid <= 1'b0;
         x_index   <= 5'd0;
         pix_valid <= 1'b0;
         underrun  <= 1'b0;
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
         hdouble_q <= hdouble;
         phase     <= 1'b0;
`endif
      end else begin
         case (state)
            PRIME: begin
               if (xfer && !cur_valid) begin
                  pixword   <= bus.word_data;
                  cur_valid <= 1'b1;
               end else if (xfer) begin
                  pre_data  <= bus.word_data;
                  pre_valid <= 1'b1;
                  pix_valid <= 1'b1;
                  x_index   <= 5'd0;
                  state     <= RUN;
               end
            end
            RUN: begin
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
               if (pix_en) phase <= !phase;
`endif
               if (advance_word && pre_valid) begin
                  pixword   <= pre_data;
                  x_index   <= 5'd0;
                  pre_valid <= xfer;
                  if (xfer) pre_data <= bus.word_data;
               end else if (advance_word) begin
                  pix_valid <= 1'b0;
                  underrun  <= 1'b1;
                  cur_valid <= 1'b0;
                  state     <= UNDERRUN;
               end else begin
                  if (act) x_index <= x_index + step[4:0];
                  if (xfer) begin
                     pre_data  <= bus.word_data;
                     pre_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_video_pixel_sequencer.sv
// tb_video_pixel_sequencer: directed vector bench for the pixel sequencer
module tb_video_pixel_sequencer;
   typedef struct {
      logic        ls, pe, wv;
      logic [2:0]  m;
      logic [31:0] wd;
      logic        rdy, pv, ur;
      logic [4:0]  x;
      logic [31:0] pw;
   } vec_t;
   logic        clk = 1'b0, reset = 1'b1, line_start = 1'b0, pix_en = 1'b0;
   logic [2:0]  mode = 3'd0;
   logic [31:0] pixword;
   logic [4:0]  x_index;
   logic        pix_valid, underrun;
   int          errors = 0, checks = 0;
   vec_t        tbl[12];
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
   logic        hdouble = 1'b0;
`endif
   video_pixel_sequencer_if bus();
   video_pixel_sequencer dut (
      .clk(clk), .reset(reset), .mode(mode), .line_start(line_start), .pix_en(pix_en),
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
      .hdouble(hdouble),
`endif
      .bus(bus), .pixword(pixword), .x_index(x_index), .pix_valid(pix_valid), .underrun(underrun));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   task automatic apply(input logic ls, input logic pe, input logic [2:0] m, input logic wv, input logic [31:0] wd);
      @(negedge clk);
      line_start = ls;
      pix_en = pe;
      mode = m;
      bus.word_valid = wv;
      bus.word_data = wd;
      #1;
   endtask
   function automatic logic [31:0] w(input int k);
      return 32'hA000_0000 + k;
   endfunction
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int k;
      tbl[0] = '{1, 1, 1, 3'd2, 32'h7654_3210, 0, 0, 0, 5'd0, 32'h0};
      tbl[1] = '{0, 1, 1, 3'd2, 32'h7654_3210, 1, 0, 0, 5'd0, 32'h0};
      tbl[2] = '{0, 1, 1, 3'd2, 32'hFEDC_BA98, 1, 0, 0, 5'd0, 32'h7654_3210};
      for (int i = 3; i <= 10; i++)
         tbl[i] = '{0, 1, 1, 3'd2, 32'h3333_3333, i == 10, 1, 0, 5'((i - 3) * 4), 32'h7654_3210};
      tbl[11] = '{0, 1, 1, 3'd2, 32'h4444_4444, 0, 1, 0, 5'd0, 32'hFEDC_BA98};
      bus.word_valid = 1'b0;
      bus.word_data = 32'h0;
      // power-on reset with a word offered
      apply(0, 1, 3'd0, 1, 32'hDEAD_BEEF);
      apply(0, 1, 3'd0, 1, 32'hDEAD_BEEF);
      chk("reset_ready", bus.word_ready, 0);
      chk("reset_pv", pix_valid, 0);
      chk("reset_x", x_index, 0);
      chk("reset_pw", pixword, 0);
      chk("reset_ur", underrun, 0);
      reset = 1'b0;
      apply(0, 1, 3'd0, 1, 32'hDEAD_BEEF);
      chk("idle_ready", bus.word_ready, 0);
      // test 1: 4bpp table
      for (int i = 0; i < 12; i++) begin
         apply(tbl[i].ls, tbl[i].pe, tbl[i].m, tbl[i].wv, tbl[i].wd);
         chk($sformatf("t1_ready[%0d]", i), bus.word_ready, tbl[i].rdy);
         chk($sformatf("t1_pv[%0d]", i), pix_valid, tbl[i].pv);
         chk($sformatf("t1_x[%0d]", i), x_index, tbl[i].x);
         chk($sformatf("t1_pw[%0d]", i), pixword, tbl[i].pw);
         chk($sformatf("t1_ur[%0d]", i), underrun, tbl[i].ur);
      end
      // test 2: 16bpp, FIFO always valid, no bubbles
      apply(1, 1, 3'd4, 1, w(0));
      apply(0, 1, 3'd4, 1, w(0));
      apply(0, 1, 3'd4, 1, w(1));
      k = 2;
      for (int p = 0; p < 64; p++) begin
         apply(0, 1, 3'd4, 1, w(k));
         chk($sformatf("t2_pv[%0d]", p), pix_valid, 1);
         chk($sformatf("t2_x[%0d]", p), x_index, (p % 2) * 16);
         chk($sformatf("t2_pw[%0d]", p), pixword, w(p / 2));
         chk($sformatf("t2_ready[%0d]", p), bus.word_ready, p % 2);
         if (p % 2 == 1) k++;
      end
      chk("t2_ur", underrun, 0);
      // reset mid-line with a word offered
      reset = 1'b1;
      apply(0, 1, 3'd4, 1, 32'hBAD0_0000);
      chk("mid_reset_ready", bus.word_ready, 0);
      reset = 1'b0;
      apply(0, 1, 3'd4, 1, 32'hBAD0_0001);
      chk("mid_reset_pv", pix_valid, 0);
      chk("mid_reset_x", x_index, 0);
      chk("mid_reset_pw", pixword, 0);
      chk("mid_reset_ready_idle", bus.word_ready, 0);
      // test 3: 1bpp, FIFO dries up after two words
      apply(1, 1, 3'd0, 1, 32'h1111_0000);
      apply(0, 1, 3'd0, 1, 32'h1111_0000);
      apply(0, 1, 3'd0, 1, 32'h2222_0000);
      for (int p = 0; p < 64; p++) begin
         apply(0, 1, 3'd0, 0, 32'h0);
         chk($sformatf("t3_pv[%0d]", p), pix_valid, 1);
         chk($sformatf("t3_x[%0d]", p), x_index, p % 32);
         chk($sformatf("t3_pw[%0d]", p), pixword, p < 32 ? 32'h1111_0000 : 32'h2222_0000);
         chk($sformatf("t3_ur[%0d]", p), underrun, 0);
      end
      for (int i = 0; i < 3; i++) begin
         apply(0, 1, 3'd0, 1, 32'h5555_0000);
         chk($sformatf("t3_under_pv[%0d]", i), pix_valid, 0);
         chk($sformatf("t3_under_ur[%0d]", i), underrun, 1);
         chk($sformatf("t3_under_ready[%0d]", i), bus.word_ready, 0);
      end
      // test 4: line_start recovers from underrun, then a mid-line flush drops the offered word
      apply(1, 1, 3'd3, 1, 32'hC000_0000);
      chk("t4_ls_ready", bus.word_ready, 0);
      apply(0, 1, 3'd3, 1, 32'hC000_0001);
      chk("t4_ur_clear", underrun, 0);
      chk("t4_pv_clear", pix_valid, 0);
      chk("t4_prime_ready", bus.word_ready, 1);
      apply(0, 1, 3'd3, 1, 32'hC000_0002);
      apply(0, 1, 3'd3, 1, 32'hC000_0003);
      chk("t4_run_pw", pixword, 32'hC000_0001);
      chk("t4_run_x0", x_index, 0);
      apply(0, 1, 3'd3, 1, 32'hC000_0003);
      chk("t4_run_x8", x_index, 8);
      apply(1, 1, 3'd3, 1, 32'hD000_0000);
      chk("t4_flush_ready", bus.word_ready, 0);
      chk("t4_pre_flush_x", x_index, 16);
      apply(0, 1, 3'd3, 1, 32'hD000_0001);
      chk("t4_flush_x", x_index, 0);
      chk("t4_flush_pv", pix_valid, 0);
      chk("t4_reprime_ready", bus.word_ready, 1);
      apply(0, 1, 3'd3, 1, 32'hD000_0002);
      apply(0, 1, 3'd3, 0, 32'h0);
      chk("t4_reprime_pv", pix_valid, 1);
      chk("t4_reprime_pw", pixword, 32'hD000_0001);
      // test 5: mode latched at line_start only
      apply(1, 1, 3'd0, 1, 32'hE000_0000);
      apply(0, 1, 3'd3, 1, 32'hE000_0001);
      apply(0, 1, 3'd3, 1, 32'hE000_0002);
      for (int p = 0; p < 4; p++) begin
         apply(0, 1, 3'd3, 0, 32'h0);
         chk($sformatf("t5_x1[%0d]", p), x_index, p);
      end
      apply(1, 1, 3'd3, 1, 32'hF000_0000);
      apply(0, 1, 3'd0, 1, 32'hF000_0001);
      apply(0, 1, 3'd0, 1, 32'hF000_0002);
      for (int p = 0; p < 4; p++) begin
         apply(0, 1, 3'd0, 0, 32'h0);
         chk($sformatf("t5_x8[%0d]", p), x_index, p * 8);
      end
`ifdef VIDEO_PIXSEQ_DOUBLE_EN
      // test 6: pixel doubling at 8bpp
      hdouble = 1'b1;
      apply(1, 1, 3'd3, 1, w(100));
      hdouble = 1'b0;
      apply(0, 1, 3'd3, 1, w(100));
      apply(0, 1, 3'd3, 1, w(101));
      k = 102;
      for (int p = 0; p < 16; p++) begin
         apply(0, 1, 3'd3, 1, w(k));
         chk($sformatf("t6_x[%0d]", p), x_index, ((p / 2) % 4) * 8);
         chk($sformatf("t6_pw[%0d]", p), pixword, w(100 + p / 8));
         chk($sformatf("t6_ready[%0d]", p), bus.word_ready, p % 8 == 7);
         if (p % 8 == 7) k++;
      end
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
